// File: rtl/cal_pkg.sv
// Shared calendar types and date helpers: FSM state encoding, month lengths,
// leap-year rule and loaded-date validation.
package cal_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_VALIDATE = 2'd1,
        ST_ADVANCE  = 2'd2
    } cal_state_e;

    localparam logic [6:0] YEAR_MAX  = 7'd99;
    localparam logic [4:0] MONTH_MAX = 5'd12;

    // Indexed by month number; entry 0 and 13..15 are not months.
    localparam logic [4:0] DAYS_IN_MONTH [16] = '{
        5'd0,  5'd31, 5'd28, 5'd31, 5'd30, 5'd31, 5'd30, 5'd31,
        5'd31, 5'd30, 5'd31, 5'd30, 5'd31, 5'd0,  5'd0,  5'd0
    };

    function automatic logic is_leap(input logic [6:0] year);
        return ((year & 7'd3) == 7'd0);
    endfunction

    function automatic logic [4:0] days_in_month(input logic [4:0] month, input logic [6:0] year);
        logic [4:0] dim;
        if (month > MONTH_MAX) begin
            dim = 5'd0;
        end else if ((month == 5'd2) && is_leap(year)) begin
            dim = 5'd29;
        end else begin
            dim = DAYS_IN_MONTH[month[3:0]];
        end
        return dim;
    endfunction

    // A zero length for a bad month also rejects month 0 and 13..31.
    function automatic logic date_valid(input logic [6:0] year, input logic [4:0] month,
                                        input logic [4:0] day);
        return (year <= YEAR_MAX) && (day != 5'd0) && (day <= days_in_month(month, year));
    endfunction

endpackage

// File: rtl/calendar_day_sequencer_if.sv
// Request/status bundle between the date sequencer and its requesters and display consumers.
interface calendar_day_sequencer_if;
    logic       day_tick;
    logic       set_valid;
    logic       set_ready;
    logic [6:0] set_year;
    logic [4:0] set_month;
    logic [4:0] set_day;
    logic       set_error;
    logic       adv_valid;
    logic       adv_ready;
    logic [7:0] adv_count;
    logic [6:0] year;
    logic [4:0] month;
    logic [4:0] day;
    logic       month_end;
    logic       year_wrap;
    logic       busy;

    modport master (
        output day_tick, set_valid, set_year, set_month, set_day, adv_valid, adv_count,
        input  set_ready, set_error, adv_ready, year, month, day, month_end, year_wrap, busy
    );

    modport slave (
        input  day_tick, set_valid, set_year, set_month, set_day, adv_valid, adv_count,
        output set_ready, set_error, adv_ready, year, month, day, month_end, year_wrap, busy
    );
endinterface

// File: rtl/calendar_next_date.sv
// Combinational one-day increment of a (year, month, day) date, 00..99 wrapping.
// year_roll_o flags any Dec-31 rollover; the caller qualifies the century wrap.
module calendar_next_date
    import cal_pkg::*;
(
    input  logic [6:0] year_i,
    input  logic [4:0] month_i,
    input  logic [4:0] day_i,
    output logic [6:0] year_o,
    output logic [4:0] month_o,
    output logic [4:0] day_o,
    output logic       month_roll_o,
    output logic       year_roll_o
);
    logic [4:0] dim_s;

    // Next calendar date with month and year carry
    always_comb begin
        dim_s        = days_in_month(month_i, year_i);
        year_o       = year_i;
        month_o      = month_i;
        day_o        = day_i;
        month_roll_o = 1'b0;
        year_roll_o  = 1'b0;
        if (day_i < dim_s) begin
            day_o = day_i + 5'd1;
        end else begin
            day_o        = 5'd1;
            month_roll_o = 1'b1;
            if (month_i >= MONTH_MAX) begin
                month_o     = 5'd1;
                year_roll_o = 1'b1;
                if (year_i >= YEAR_MAX) begin
                    year_o = 7'd0;
                end else begin
                    year_o = year_i + 7'd1;
                end
            end else begin
                month_o = month_i + 5'd1;
            end
        end
    end
endmodule

// File: rtl/calendar_day_sequencer.sv
// Owner of the calendar date registers: arbitrates day ticks, date loads and
// multi-day advances onto a single shared next-date incrementer.
module calendar_day_sequencer
    import cal_pkg::*;
#(
    parameter logic [6:0]  RESET_YEAR  = 7'd1,
    parameter logic [4:0]  RESET_MONTH = 5'd1,
    parameter logic [4:0]  RESET_DAY   = 5'd1,
    parameter int unsigned PEND_W      = 4
) (
    input logic                   clk,
    input logic                   reset,
    calendar_day_sequencer_if.slave bus
);
    localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};
    localparam logic [PEND_W-1:0] PEND_ONE  = {{(PEND_W-1){1'b0}}, 1'b1};
    localparam logic [PEND_W-1:0] PEND_ZERO = {PEND_W{1'b0}};

    cal_state_e        state_q;
    logic [6:0]        year_q;
    logic [4:0]        month_q;
    logic [4:0]        day_q;
    logic [6:0]        set_year_q;
    logic [4:0]        set_month_q;
    logic [4:0]        set_day_q;
    logic [7:0]        adv_cnt_q;
    logic [PEND_W-1:0] pend_q;
    logic [PEND_W-1:0] pend_d;
    logic [PEND_W-1:0] pend_tick_s;
    logic              set_error_q;
    logic              month_end_q;
    logic              year_wrap_q;

    logic [6:0]        year_d;
    logic [4:0]        month_d;
    logic [4:0]        day_d;
    logic              month_roll_s;
    logic              year_roll_s;
    logic              idle_s;
    logic              pend_nz_s;
    logic              set_ok_s;
    logic              step_s;

    calendar_next_date u_next_date (
        .year_i       (year_q),
        .month_i      (month_q),
        .day_i        (day_q),
        .year_o       (year_d),
        .month_o      (month_d),
        .day_o        (day_d),
        .month_roll_o (month_roll_s),
        .year_roll_o  (year_roll_s)
    );

    // Step-source arbitration and pending-tick bookkeeping
    always_comb begin
        idle_s    = (state_q == ST_IDLE);
        pend_nz_s = (pend_q != PEND_ZERO);
        set_ok_s  = date_valid(set_year_q, set_month_q, set_day_q);
        if (!bus.day_tick) begin
            pend_tick_s = pend_q;
        end else if (pend_q == PEND_MAX) begin
            pend_tick_s = pend_q;
        end else begin
            pend_tick_s = pend_q + PEND_ONE;
        end
        step_s = 1'b0;
        pend_d = pend_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.set_valid || bus.adv_valid) begin
                    pend_d = pend_tick_s;
                end else if (bus.day_tick) begin
                    step_s = 1'b1;
                end else if (pend_nz_s) begin
                    step_s = 1'b1;
                    pend_d = pend_q - PEND_ONE;
                end else begin
                    step_s = 1'b0;
                end
            end
            ST_VALIDATE: begin
                // A successful load makes any backlog of ticks meaningless.
                if (set_ok_s) begin
                    pend_d = PEND_ZERO;
                end else begin
                    pend_d = pend_tick_s;
                end
            end
            ST_ADVANCE: begin
                pend_d = pend_tick_s;
                if (adv_cnt_q != 8'd0) begin
                    step_s = 1'b1;
                end else begin
                    step_s = 1'b0;
                end
            end
            default: begin
                pend_d = PEND_ZERO;
                step_s = 1'b0;
            end
        endcase
    end

    // FSM, date registers, pending counter and registered status pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            year_q      <= RESET_YEAR;
            month_q     <= RESET_MONTH;
            day_q       <= RESET_DAY;
            set_year_q  <= 7'd0;
            set_month_q <= 5'd0;
            set_day_q   <= 5'd0;
            adv_cnt_q   <= 8'd0;
            pend_q      <= PEND_ZERO;
            set_error_q <= 1'b0;
            month_end_q <= 1'b0;
            year_wrap_q <= 1'b0;
        end else begin
            pend_q      <= pend_d;
            set_error_q <= 1'b0;
            month_end_q <= step_s & month_roll_s;
            year_wrap_q <= step_s & year_roll_s & (year_q == YEAR_MAX);
            if (step_s) begin
                year_q  <= year_d;
                month_q <= month_d;
                day_q   <= day_d;
            end
            case (state_q)
                ST_IDLE: begin
                    if (bus.set_valid) begin
                        set_year_q  <= bus.set_year;
                        set_month_q <= bus.set_month;
                        set_day_q   <= bus.set_day;
                        state_q     <= ST_VALIDATE;
                    end else if (bus.adv_valid) begin
                        adv_cnt_q <= bus.adv_count;
                        state_q   <= ST_ADVANCE;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_VALIDATE: begin
                    state_q <= ST_IDLE;
                    if (set_ok_s) begin
                        year_q  <= set_year_q;
                        month_q <= set_month_q;
                        day_q   <= set_day_q;
                    end else begin
                        set_error_q <= 1'b1;
                    end
                end
                ST_ADVANCE: begin
                    if (adv_cnt_q <= 8'd1) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_ADVANCE;
                    end
                    if (adv_cnt_q != 8'd0) begin
                        adv_cnt_q <= adv_cnt_q - 8'd1;
                    end else begin
                        adv_cnt_q <= 8'd0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.set_ready = idle_s;
    assign bus.adv_ready = idle_s & ~bus.set_valid;
    assign bus.busy      = ~idle_s | pend_nz_s;
    assign bus.set_error = set_error_q;
    assign bus.month_end = month_end_q;
    assign bus.year_wrap = year_wrap_q;
    assign bus.year      = year_q;
    assign bus.month     = month_q;
    assign bus.day       = day_q;
endmodule

// File: tb/tb_calendar_day_sequencer.sv
// Self-checking bench for calendar_day_sequencer: directed table/sequences plus
// randomized traffic compared every cycle against a day-ordinal reference model.
module tb_calendar_day_sequencer;
    localparam int PMAX     = 15;
    localparam int CENTURY  = 36525;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    calendar_day_sequencer_if bus();

    calendar_day_sequencer #(
        .RESET_YEAR (7'd1),
        .RESET_MONTH(5'd1),
        .RESET_DAY  (5'd1),
        .PEND_W     (4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: date kept as days since 2000-01-01
    int m_ord, m_mode, m_pend, m_cnt, m_sy, m_sm, m_sd;
    bit m_me, m_yw, m_err;

    typedef struct {
        bit do_set;
        int sy, sm, sd;
        int ticks;
        bit exp_err;
        int ey, em, ed;
        bit exp_me, exp_yw;
    } set_vec_t;
    set_vec_t vecs[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic int ydays(input int y);
        return (y % 4 == 0) ? 366 : 365;
    endfunction

    function automatic int mdays(input int m, input int y);
        case (m)
            2: return (y % 4 == 0) ? 29 : 28;
            4, 6, 9, 11: return 30;
            1, 3, 5, 7, 8, 10, 12: return 31;
            default: return 0;
        endcase
    endfunction

    function automatic int to_ord(input int y, input int m, input int d);
        int o;
        o = 0;
        for (int i = 0; i < y; i++) o += ydays(i);
        for (int i = 1; i < m; i++) o += mdays(i, y);
        return o + d - 1;
    endfunction

    task automatic from_ord(input int o, output int y, output int m, output int d);
        int r;
        r = o;
        y = 0;
        while (r >= ydays(y)) begin r -= ydays(y); y++; end
        m = 1;
        while (r >= mdays(m, y)) begin r -= mdays(m, y); m++; end
        d = r + 1;
    endtask

    function automatic bit valid_date(input int y, input int m, input int d);
        return (y <= 99) && (m >= 1) && (m <= 12) && (d >= 1) && (d <= mdays(m, y));
    endfunction

    task automatic model_reset();
        m_ord = to_ord(1, 1, 1);
        m_mode = 0; m_pend = 0; m_cnt = 0;
        m_me = 0; m_yw = 0; m_err = 0;
    endtask

    task automatic model_day();
        int y, m, d;
        m_ord = (m_ord + 1) % CENTURY;
        from_ord(m_ord, y, m, d);
        m_me = (d == 1);
        m_yw = (m_ord == 0);
    endtask

    task automatic model_step(input bit tick, input bit sv, input int sy, input int sm,
                              input int sd, input bit av, input int ac);
        int tp;
        tp = tick ? ((m_pend < PMAX) ? m_pend + 1 : PMAX) : m_pend;
        m_me = 0; m_yw = 0; m_err = 0;
        if (m_mode == 0) begin
            if (sv) begin
                m_sy = sy; m_sm = sm; m_sd = sd; m_mode = 1; m_pend = tp;
            end else if (av) begin
                m_cnt = ac; m_mode = 2; m_pend = tp;
            end else if (tick) begin
                model_day();
            end else if (m_pend > 0) begin
                model_day();
                m_pend--;
            end
        end else if (m_mode == 1) begin
            if (valid_date(m_sy, m_sm, m_sd)) begin
                m_ord = to_ord(m_sy, m_sm, m_sd);
                m_pend = 0;
            end else begin
                m_err = 1;
                m_pend = tp;
            end
            m_mode = 0;
        end else begin
            m_pend = tp;
            if (m_cnt == 0) begin
                m_mode = 0;
            end else begin
                model_day();
                m_cnt--;
                if (m_cnt == 0) m_mode = 0;
            end
        end
    endtask

    task automatic compare_model();
        int y, m, d;
        from_ord(m_ord, y, m, d);
        check("model_state",
              {bus.year, bus.month, bus.day, bus.month_end, bus.year_wrap, bus.set_error,
               bus.busy, bus.set_ready},
              {7'(y), 5'(m), 5'(d), m_me, m_yw, m_err, (m_mode != 0 || m_pend != 0),
               (m_mode == 0)});
    endtask

    task automatic cycle(input bit tick, input bit sv, input int sy, input int sm, input int sd,
                         input bit av, input int ac);
        bus.day_tick  = tick;
        bus.set_valid = sv;
        bus.set_year  = sy[6:0];
        bus.set_month = sm[4:0];
        bus.set_day   = sd[4:0];
        bus.adv_valid = av;
        bus.adv_count = ac[7:0];
        model_step(tick, sv, sy, sm, sd, av, ac);
        @(posedge clk);
        #1;
        bus.day_tick  = 1'b0;
        bus.set_valid = 1'b0;
        bus.adv_valid = 1'b0;
        compare_model();
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 0, 0, 0, 1'b0, 0);
    endtask

    task automatic tick();
        cycle(1'b1, 1'b0, 0, 0, 0, 1'b0, 0);
    endtask

    task automatic set_date(input int y, input int m, input int d);
        cycle(1'b0, 1'b1, y, m, d, 1'b0, 0);
        idle();
    endtask

    task automatic check_date(input string name, input int y, input int m, input int d);
        check(name, {bus.year, bus.month, bus.day}, {7'(y), 5'(m), 5'(d)});
    endtask

    initial begin
        int me_cnt, busy_cnt;
        vecs[0]  = '{1'b1,   3,  2, 28, 1, 1'b0,  3,  3,  1, 1'b1, 1'b0};
        vecs[1]  = '{1'b1,   4,  2, 28, 1, 1'b0,  4,  2, 29, 1'b0, 1'b0};
        vecs[2]  = '{1'b0,   0,  0,  0, 1, 1'b0,  4,  3,  1, 1'b1, 1'b0};
        vecs[3]  = '{1'b1,  99, 12, 31, 1, 1'b0,  0,  1,  1, 1'b1, 1'b1};
        vecs[4]  = '{1'b1,   5,  2, 29, 0, 1'b1,  0,  1,  1, 1'b0, 1'b0};
        vecs[5]  = '{1'b1,   5, 13,  1, 0, 1'b1,  0,  1,  1, 1'b0, 1'b0};
        vecs[6]  = '{1'b1,   5,  4, 31, 0, 1'b1,  0,  1,  1, 1'b0, 1'b0};
        vecs[7]  = '{1'b1,   5,  0,  5, 0, 1'b1,  0,  1,  1, 1'b0, 1'b0};
        vecs[8]  = '{1'b1,   5,  6,  0, 0, 1'b1,  0,  1,  1, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 100,  1,  1, 0, 1'b1,  0,  1,  1, 1'b0, 1'b0};
        vecs[10] = '{1'b1,   0,  2, 29, 0, 1'b0,  0,  2, 29, 1'b0, 1'b0};
        vecs[11] = '{1'b1,   7,  4, 30, 1, 1'b0,  7,  5,  1, 1'b1, 1'b0};
        vecs[12] = '{1'b1,   5, 31,  1, 0, 1'b1,  7,  5,  1, 1'b0, 1'b0};

        bus.day_tick = 1'b0; bus.set_valid = 1'b0; bus.adv_valid = 1'b0;
        bus.set_year = 7'd0; bus.set_month = 5'd0; bus.set_day = 5'd0; bus.adv_count = 8'd0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();

        check_date("reset_date", 1, 1, 1);
        check("reset_ready", {bus.set_ready, bus.adv_ready}, 2'b11);
        check("reset_flags", {bus.busy, bus.set_error, bus.month_end, bus.year_wrap}, 4'b0000);

        // 31 consecutive ticks cross January once
        me_cnt = 0;
        for (int i = 0; i < 31; i++) begin
            tick();
            me_cnt += int'(bus.month_end);
        end
        check_date("tick31_date", 1, 2, 1);
        check("tick31_month_end_count", me_cnt, 1);

        for (int i = 0; i < 13; i++) begin
            if (vecs[i].do_set) begin
                set_date(vecs[i].sy, vecs[i].sm, vecs[i].sd);
                check($sformatf("vec%0d_set_error", i), bus.set_error, vecs[i].exp_err);
            end
            for (int t = 0; t < vecs[i].ticks; t++) tick();
            check_date($sformatf("vec%0d_date", i), vecs[i].ey, vecs[i].em, vecs[i].ed);
            check($sformatf("vec%0d_pulses", i), {bus.month_end, bus.year_wrap},
                  {vecs[i].exp_me, vecs[i].exp_yw});
        end

        // 40-day advance with three ticks queued behind it
        set_date(24, 1, 1);
        cycle(1'b0, 1'b0, 0, 0, 0, 1'b1, 40);
        check("adv40_not_ready", bus.set_ready, 1'b0);
        for (int i = 1; i <= 40; i++) begin
            cycle((i == 5 || i == 10 || i == 15), 1'b0, 0, 0, 0, 1'b0, 0);
            if (i == 39) begin
                check_date("adv40_day39", 24, 2, 9);
                check("adv40_still_busy", bus.set_ready, 1'b0);
            end
        end
        check_date("adv40_done", 24, 2, 10);
        check("adv40_idle_pending", {bus.set_ready, bus.busy}, 2'b11);
        repeat (3) idle();
        check_date("adv40_drained", 24, 2, 13);
        check("adv40_not_busy", bus.busy, 1'b0);

        // Simultaneous set and advance: set wins
        bus.set_valid = 1'b1; bus.adv_valid = 1'b1;
        #1;
        check("both_ready", {bus.set_ready, bus.adv_ready}, 2'b10);
        cycle(1'b0, 1'b1, 10, 6, 15, 1'b1, 5);
        check("both_adv_ready_low", bus.adv_ready, 1'b0);
        idle();
        check_date("both_set_loaded", 10, 6, 15);
        idle();
        check_date("both_no_advance", 10, 6, 15);

        // Zero-length advance
        cycle(1'b0, 1'b0, 0, 0, 0, 1'b1, 0);
        check("adv0_busy", bus.set_ready, 1'b0);
        idle();
        check("adv0_back_idle", bus.set_ready, 1'b1);
        check_date("adv0_date", 10, 6, 15);

        // Pending counter saturation
        cycle(1'b0, 1'b0, 0, 0, 0, 1'b1, 30);
        for (int i = 0; i < 30; i++) tick();
        busy_cnt = int'(bus.busy);
        for (int i = 0; i < 20; i++) begin
            idle();
            busy_cnt += int'(bus.busy);
        end
        check("sat_drain_cycles", busy_cnt, 15);
        check_date("sat_date", 10, 7, 30);

        // Asynchronous reset in the middle of an advance
        cycle(1'b0, 1'b0, 0, 0, 0, 1'b1, 100);
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        check_date("midreset_date", 1, 1, 1);
        check("midreset_flags", {bus.busy, bus.set_ready, bus.adv_ready}, 3'b011);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        repeat (3) idle();
        check_date("midreset_no_drain", 1, 1, 1);

        // Randomized traffic against the model
        for (int n = 0; n < 800; n++) begin
            int r;
            bit tk, sv, av;
            r  = int'($urandom_range(0, 99));
            tk = ($urandom_range(0, 3) == 0);
            sv = (r < 6);
            av = (r >= 6) && (r < 12);
            cycle(tk, sv, int'($urandom_range(0, 110)), int'($urandom_range(0, 14)),
                  int'($urandom_range(0, 32)), av, int'($urandom_range(0, 20)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
